// File: rtl/sim_top_bd_wrapper.sv
// sim_top_bd_wrapper
//   FIOS/CIOS Montgomery multiplier (17-bit limbs, R = 2^(17*S)) sharing a
//   true-dual-port 1024x32 RAM with a host. Port A belongs to the host and
//   port B to the core. The core loads p'0, p, a and b from RAM and computes
//   (a*b + m*p)/R without a final subtraction. It then writes the S result
//   limbs back to words 0..S-1.
// Ports
//   BRAM_PORTA_i_clk  : single clock, rising edge
//   reset_i           : synchronous active-high core reset (RAM preserved)
//   start_i           : launch pulse, honoured in IDLE or DONE only
//   done_o            : high while the core sits in DONE
//   BRAM_PORTA_i_addr : host byte address (word = addr[11:2])
//   BRAM_PORTA_i_din  : host write data
//   BRAM_PORTA_i_we   : host byte write enables
//   BRAM_PORTA_i_dout : host read data, registered (1-cycle latency)
//   BRAM_PORTA_i_rst  : synchronous clear of the dout register only
//   BRAM_PORTA_i_en   : host port enable
module sim_top_bd_wrapper #(
    parameter int WIDTH = 256
) (
    input  logic        BRAM_PORTA_i_clk,
    input  logic        reset_i,
    input  logic        start_i,
    output logic        done_o,
    input  logic [31:0] BRAM_PORTA_i_addr,
    input  logic [31:0] BRAM_PORTA_i_din,
    input  logic [3:0]  BRAM_PORTA_i_we,
    output logic [31:0] BRAM_PORTA_i_dout,
    input  logic        BRAM_PORTA_i_rst,
    input  logic        BRAM_PORTA_i_en
);

    localparam int S     = (WIDTH + 1) / 17 + 1;
    localparam int DEPTH = 1024;
    localparam int IW    = $clog2(S + 2);
    localparam int LW    = $clog2(3 * S + 2);

    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, STORE, DONE} state_t;
    typedef enum logic [1:0] {PH_MUL, PH_MCALC, PH_RED} phase_t;

    logic clk;
    assign clk = BRAM_PORTA_i_clk;

    // ---------------- dual-port RAM ----------------
    logic [31:0] mem [DEPTH];
    logic [9:0]  a_idx;
    logic [31:0] dout_q;
    logic        b_we;
    logic [9:0]  b_addr;
    logic [31:0] b_din;
    logic [31:0] b_rdata_q;

    assign a_idx             = BRAM_PORTA_i_addr[11:2];
    assign BRAM_PORTA_i_dout = dout_q;

    // Both write ports live in one process so the array has a single driver.
    always_ff @(posedge clk) begin
        if (BRAM_PORTA_i_en) begin
            if (BRAM_PORTA_i_we[0]) mem[a_idx][7:0]   <= BRAM_PORTA_i_din[7:0];
            if (BRAM_PORTA_i_we[1]) mem[a_idx][15:8]  <= BRAM_PORTA_i_din[15:8];
            if (BRAM_PORTA_i_we[2]) mem[a_idx][23:16] <= BRAM_PORTA_i_din[23:16];
            if (BRAM_PORTA_i_we[3]) mem[a_idx][31:24] <= BRAM_PORTA_i_din[31:24];
        end
        if (b_we) mem[b_addr] <= b_din;
    end

    // Read-first: dout takes the pre-write contents on a simultaneous write.
    always_ff @(posedge clk) begin
        if (BRAM_PORTA_i_en) begin
            if (BRAM_PORTA_i_rst) dout_q <= '0;
            else                  dout_q <= mem[a_idx];
        end
    end

    always_ff @(posedge clk) begin
        b_rdata_q <= mem[b_addr];
    end

    // ---------------- core state ----------------
    state_t            state_q, state_d;
    phase_t            ph_q, ph_d;
    logic [IW-1:0]     i_q, i_d, j_q, j_d, st_q, st_d;
    logic [LW-1:0]     ld_q, ld_d, slot;
    logic              launch;
    logic [18:0]       c_q;
    logic [16:0]       m_q, p0_q;
    logic [17*S-1:0]   p_q, a_q, b_q;
    logic [17*(S+2)-1:0] t_q;

    logic [IW-1:0]     jx;
    logic [16:0]       mx, my, t_j;
    logic [33:0]       prod;
    logic [35:0]       sum_mac;
    logic [19:0]       sum_tail;

    logic unused_bits;
    assign unused_bits = ^{BRAM_PORTA_i_addr[31:12], BRAM_PORTA_i_addr[1:0], b_rdata_q[31:17]};

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        i_d     = i_q;
        j_d     = j_q;
        ld_d    = ld_q;
        st_d    = st_q;
        launch  = 1'b0;
        done_o  = 1'b0;
        b_we    = 1'b0;
        b_addr  = 10'(ld_q);
        b_din   = {15'b0, t_q[17*int'(st_q) +: 17]};
        case (state_q)
            IDLE, DONE: begin
                done_o = (state_q == DONE);
                if (start_i) begin
                    state_d = LOAD;
                    ld_d    = '0;
                    launch  = 1'b1;
                end
            end
            LOAD: begin
                ld_d = ld_q + LW'(1);
                if (ld_q == LW'(3 * S + 1)) begin
                    state_d = COMPUTE;
                    ph_d    = PH_MUL;
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            COMPUTE: begin
                case (ph_q)
                    PH_MUL: begin
                        if (j_q == IW'(S)) begin
                            ph_d = PH_MCALC;
                            j_d  = '0;
                        end else begin
                            j_d = j_q + IW'(1);
                        end
                    end
                    PH_MCALC: begin
                        ph_d = PH_RED;
                        j_d  = '0;
                    end
                    default: begin
                        if (j_q == IW'(S)) begin
                            j_d = '0;
                            if (i_q == IW'(S - 1)) begin
                                state_d = STORE;
                                st_d    = '0;
                            end else begin
                                i_d  = i_q + IW'(1);
                                ph_d = PH_MUL;
                            end
                        end else begin
                            j_d = j_q + IW'(1);
                        end
                    end
                endcase
            end
            STORE: begin
                b_we   = 1'b1;
                b_addr = 10'(st_q);
                st_d   = st_q + IW'(1);
                if (st_q == IW'(S - 1)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // One shared 17x17 multiplier: a_j*b_i, then t0*p'0, then m*p_j.
    always_comb begin
        jx = (j_q < IW'(S)) ? j_q : '0;
        mx = '0;
        my = '0;
        case (ph_q)
            PH_MUL: begin
                mx = a_q[17*int'(jx) +: 17];
                my = b_q[17*int'(i_q) +: 17];
            end
            PH_MCALC: begin
                mx = t_q[16:0];
                my = p0_q;
            end
            default: begin
                mx = m_q;
                my = p_q[17*int'(jx) +: 17];
            end
        endcase
        t_j      = t_q[17*int'(j_q) +: 17];
        prod     = 34'(mx) * 34'(my);
        sum_mac  = 36'(t_j) + 36'(prod) + 36'(c_q);
        sum_tail = 20'(t_j) + 20'(c_q);
    end

    assign slot = ld_q - LW'(1);

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q <= IDLE;
            ph_q    <= PH_MUL;
            i_q     <= '0;
            j_q     <= '0;
            ld_q    <= '0;
            st_q    <= '0;
            c_q     <= '0;
            m_q     <= '0;
            p0_q    <= '0;
            p_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            i_q     <= i_d;
            j_q     <= j_d;
            ld_q    <= ld_d;
            st_q    <= st_d;
            if (launch) begin
                t_q <= '0;
                c_q <= '0;
                m_q <= '0;
            end
            // Read data lags the address by one cycle, so slot = ld_q - 1.
            if (state_q == LOAD && ld_q != '0) begin
                if (int'(slot) == 0)
                    p0_q <= b_rdata_q[16:0];
                else if (int'(slot) <= S)
                    p_q[17*(int'(slot) - 1) +: 17] <= b_rdata_q[16:0];
                else if (int'(slot) <= 2 * S)
                    a_q[17*(int'(slot) - 1 - S) +: 17] <= b_rdata_q[16:0];
                else
                    b_q[17*(int'(slot) - 1 - 2 * S) +: 17] <= b_rdata_q[16:0];
            end
            if (state_q == COMPUTE) begin
                case (ph_q)
                    PH_MUL: begin
                        if (j_q < IW'(S)) begin
                            t_q[17*int'(j_q) +: 17] <= sum_mac[16:0];
                            c_q <= sum_mac[35:17];
                        end else begin
                            t_q[17*S +: 17]     <= sum_tail[16:0];
                            t_q[17*(S+1) +: 17] <= {14'b0, sum_tail[19:17]};
                            c_q <= '0;
                        end
                    end
                    PH_MCALC: m_q <= prod[16:0];
                    default: begin
                        // Reduction pass also shifts t down by one limb.
                        if (j_q == '0) begin
                            c_q <= sum_mac[35:17];
                        end else if (j_q < IW'(S)) begin
                            t_q[17*(int'(j_q) - 1) +: 17] <= sum_mac[16:0];
                            c_q <= sum_mac[35:17];
                        end else begin
                            t_q[17*(S-1) +: 17] <= sum_tail[16:0];
                            t_q[17*S +: 17]     <= t_q[17*(S+1) +: 17] + {14'b0, sum_tail[19:17]};
                            t_q[17*(S+1) +: 17] <= '0;
                            c_q <= '0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sim_top_bd_wrapper.sv
// Testbench for sim_top_bd_wrapper: host port checks plus Montgomery runs
// scored against a radix-2 REDC reference model through an expected queue.
module tb_sim_top_bd_wrapper;

    localparam int WIDTH  = 256;
    localparam int S      = (WIDTH + 1) / 17 + 1;
    localparam int RW     = 17 * S;
    localparam int N_RAND = 40;
    localparam int LAT_MAX = 4 * S * S + 8 * S;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic        start_i = 1'b0;
    logic        done_o;
    logic [31:0] addr = '0;
    logic [31:0] din = '0;
    logic [3:0]  we = '0;
    logic [31:0] dout;
    logic        prst = 1'b0;
    logic        en = 1'b0;

    always #5 clk = ~clk;

    sim_top_bd_wrapper #(.WIDTH(WIDTH)) dut (
        .BRAM_PORTA_i_clk  (clk),
        .reset_i           (reset_i),
        .start_i           (start_i),
        .done_o            (done_o),
        .BRAM_PORTA_i_addr (addr),
        .BRAM_PORTA_i_din  (din),
        .BRAM_PORTA_i_we   (we),
        .BRAM_PORTA_i_dout (dout),
        .BRAM_PORTA_i_rst  (prst),
        .BRAM_PORTA_i_en   (en)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int          base_lat = -1;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int idx, input logic [31:0] d, input logic [3:0] be);
        addr = 32'(idx) << 2;
        din  = d;
        we   = be;
        en   = 1'b1;
        tick();
        we = '0;
        en = 1'b0;
    endtask

    task automatic host_read(input int idx, output logic [31:0] d);
        addr = 32'(idx) << 2;
        we   = '0;
        en   = 1'b1;
        tick();
        en = 1'b0;
        d  = dout;
    endtask

    task automatic pulse_reset();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
    endtask

    // -p^-1 mod 2^17, built bit by bit so that p*x + 1 == 0 mod 2^17.
    function automatic logic [16:0] pprime(input logic [RW-1:0] p);
        logic [16:0] x, v;
        x = '0;
        for (int k = 0; k < 17; k++) begin
            v = 17'(p[16:0] * x + 17'd1);
            if (v[k]) x[k] = 1'b1;
        end
        return x;
    endfunction

    // Radix-2 REDC over 17*S bits; yields the same unique m as word-level FIOS.
    function automatic logic [RW-1:0] mont_ref(input logic [RW-1:0] p, a, b);
        logic [2*RW+15:0] t;
        t = (2*RW+16)'(a) * (2*RW+16)'(b);
        for (int k = 0; k < RW; k++) begin
            if (t[0]) t = t + (2*RW+16)'(p);
            t = t >> 1;
        end
        return t[RW-1:0];
    endfunction

    function automatic logic [RW-1:0] rnd_wide();
        logic [RW-1:0] v;
        v = '0;
        for (int k = 0; k < (RW + 31) / 32; k++) v = {v[RW-33:0], 32'($urandom)};
        return v;
    endfunction

    function automatic logic [RW-1:0] rnd_below_2p(input logic [RW-1:0] p);
        logic [RW:0] twop, r;
        twop = {p, 1'b0};
        r    = {1'b0, rnd_wide()} % twop;
        return r[RW-1:0];
    endfunction

    task automatic load_ops(input logic [RW-1:0] p, a, b);
        host_write(0, {15'b0, pprime(p)}, 4'hF);
        for (int i = 0; i < S; i++) begin
            host_write(1 + i,         {15'b0, p[17*i +: 17]}, 4'hF);
            host_write(1 + S + i,     {15'b0, a[17*i +: 17]}, 4'hF);
            host_write(1 + 2 * S + i, {15'b0, b[17*i +: 17]}, 4'hF);
        end
    endtask

    // Pushes the expected limbs, launches, waits for done and scores the RAM.
    task automatic run_and_check(input logic [RW-1:0] p, a, b, input bit extra_starts);
        logic [RW-1:0] r;
        logic [31:0]   w;
        int            lat;
        r = mont_ref(p, a, b);
        for (int i = 0; i < S; i++) exp_q.push_back({15'b0, r[17*i +: 17]});
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        lat = 0;
        while (!done_o && lat < 2 * LAT_MAX) begin
            start_i = extra_starts && (lat == 10 || lat == 300 || lat == 615);
            tick();
            lat++;
        end
        start_i = 1'b0;
        check("done_within_bound", 64'(done_o), 64'd1);
        check("latency_max", 64'(lat <= LAT_MAX), 64'd1);
        if (base_lat < 0) base_lat = lat;
        else check("latency_fixed", 64'(lat), 64'(base_lat));
        tick();
        tick();
        check("done_hold", 64'(done_o), 64'd1);
        for (int i = 0; i < S; i++) begin
            host_read(i, w);
            check("result_word", 64'(w), 64'(exp_q.pop_front()));
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [RW-1:0] pd, pr, ar, br;
        logic [31:0]   w;
        logic [RW-1:0] rr;

        pd = (RW'(1) << 255) - RW'(19);

        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        check("reset_done", 64'(done_o), 64'd0);

        // Host port behaviour
        host_write(5, 32'h0001ABCD, 4'hF);
        host_read(5, w);
        check("porta_read", 64'(w), 64'h0001ABCD);
        host_write(5, 32'h12345678, 4'hF);
        check("porta_read_first", 64'(dout), 64'h0001ABCD);
        host_write(5, 32'hFFFFFFFF, 4'b0010);
        check("porta_read_first_be", 64'(dout), 64'h12345678);
        prst = 1'b1;
        en   = 1'b1;
        tick();
        prst = 1'b0;
        en   = 1'b0;
        check("porta_rst", 64'(dout), 64'd0);
        host_read(5, w);
        check("porta_byte_enable", 64'(w), 64'h1234FF78);

        // a = 0: all-zero result
        pulse_reset();
        load_ops(pd, '0, RW'(5));
        run_and_check(pd, '0, RW'(5), 1'b0);

        pulse_reset();
        check("reset_from_done", 64'(done_o), 64'd0);

        // a = b = 1: R^-1 representative, check range and congruence too
        load_ops(pd, RW'(1), RW'(1));
        run_and_check(pd, RW'(1), RW'(1), 1'b0);
        rr = mont_ref(pd, RW'(1), RW'(1));
        check("one_range", 64'(rr < {pd[RW-2:0], 1'b0}), 64'd1);
        check("one_congruent", 64'((((2*RW)'(rr) << RW) % (2*RW)'(pd)) == (2*RW)'(1)), 64'd1);

        // Random operands, reset between vectors
        for (int v = 0; v < N_RAND; v++) begin
            pr = rnd_wide();
            pr[RW-1:WIDTH] = '0;
            pr[0] = 1'b1;
            ar = rnd_below_2p(pr);
            br = rnd_below_2p(pr);
            pulse_reset();
            load_ops(pr, ar, br);
            run_and_check(pr, ar, br, 1'b0);
        end

        // Abort mid-computation, host reads stay live while busy
        pulse_reset();
        ar = rnd_below_2p(pd);
        br = rnd_below_2p(pd);
        load_ops(pd, ar, br);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (100) tick();
        host_read(1 + S, w);
        check("read_while_busy", 64'(w), 64'({15'b0, ar[16:0]}));
        repeat (100) tick();
        pulse_reset();
        check("abort_done", 64'(done_o), 64'd0);
        ar = rnd_below_2p(pd);
        br = rnd_below_2p(pd);
        load_ops(pd, ar, br);
        run_and_check(pd, ar, br, 1'b0);

        // Restart from DONE with stray starts while busy
        ar = rnd_below_2p(pd);
        br = rnd_below_2p(pd);
        load_ops(pd, ar, br);
        run_and_check(pd, ar, br, 1'b1);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
